mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_if.sv | 21 ++
 rtl/mem_access_unit.sv | 156 +++++++++++++++
 tb/tb_mem_access_unit.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Memory-side bus of the load/store unit: a single-outstanding request
// channel with a ready-terminated response.
interface mem_access_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit between the EX/MA stage and a word-wide memory port:
// lane steering for stores, alignment/extension for loads, stall and timeout.
module mem_access_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [2:0]          funct3,
    input  logic [31:0]         address,
    input  logic [31:0]         store_data,
    mem_access_unit_if.master   bus,
    output logic [31:0]         read_data,
    output logic                stall,
    output logic                misaligned,
    output logic                bus_error
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [8:0] TIMEOUT_W = 9'(TIMEOUT);

    state_t      state_reg;
    logic        mem_req_reg;
    logic        mem_we_reg;
    logic [31:0] mem_addr_reg;
    logic [31:0] mem_wdata_reg;
    logic [3:0]  mem_wstrb_reg;
    logic [31:0] read_data_reg;
    logic        bus_error_reg;
    logic [7:0]  wait_cnt_reg;
    logic [2:0]  f3_reg;
    logic [1:0]  off_reg;
    logic        load_reg;

    logic        request;
    logic        is_store;
    logic        bad_align;
    logic [31:0] wdata_next;
    logic [3:0]  wstrb_next;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_fmt;

    // A simultaneous read and write is a store; the load is dropped.
    assign request  = mem_read | mem_write;
    assign is_store = mem_write;

    always_comb begin
        bad_align = 1'b0;
        case (funct3)
            3'b000:  bad_align = 1'b0;
            3'b001:  bad_align = address[0];
            3'b010:  bad_align = |address[1:0];
            3'b100:  bad_align = is_store;
            3'b101:  bad_align = is_store | address[0];
            default: bad_align = 1'b1;
        endcase
    end

    assign misaligned = request & bad_align;
    assign stall      = ((state_reg == IDLE) & request & ~bad_align) | (state_reg == WAIT);

    // Per-lane store steering; only aligned accesses are ever latched.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign wdata_next[gi*8 +: 8] =
                (funct3[1:0] == 2'b00) ? store_data[7:0] :
                (funct3[1:0] == 2'b01) ? store_data[(gi % 2)*8 +: 8] :
                                         store_data[gi*8 +: 8];
            assign wstrb_next[gi] =
                (funct3[1:0] == 2'b00) ? (address[1:0] == LANE) :
                (funct3[1:0] == 2'b01) ? (address[1] == LANE[1]) :
                                         1'b1;
        end
    endgenerate

    assign byte_sel = bus.mem_rdata[{off_reg, 3'b000} +: 8];
    assign half_sel = off_reg[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

    always_comb begin
        load_fmt = bus.mem_rdata;
        case (f3_reg)
            3'b000:  load_fmt = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_fmt = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_fmt = {24'd0, byte_sel};
            3'b101:  load_fmt = {16'd0, half_sel};
            default: load_fmt = bus.mem_rdata;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_reg     <= IDLE;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= 32'd0;
            mem_wdata_reg <= 32'd0;
            mem_wstrb_reg <= 4'd0;
            read_data_reg <= 32'd0;
            bus_error_reg <= 1'b0;
            wait_cnt_reg  <= 8'd0;
            f3_reg        <= 3'd0;
            off_reg       <= 2'd0;
            load_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    bus_error_reg <= 1'b0;
                    if (request && !bad_align) begin
                        mem_req_reg   <= 1'b1;
                        mem_we_reg    <= is_store;
                        mem_addr_reg  <= {address[31:2], 2'b00};
                        mem_wdata_reg <= wdata_next;
                        mem_wstrb_reg <= is_store ? wstrb_next : 4'd0;
                        f3_reg        <= funct3;
                        off_reg       <= address[1:0];
                        load_reg      <= ~is_store;
                        wait_cnt_reg  <= 8'd0;
                        state_reg     <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mem_ready) begin
                        mem_req_reg <= 1'b0;
                        if (load_reg) read_data_reg <= load_fmt;
                        state_reg   <= DONE;
                    end else if (9'(wait_cnt_reg) + 9'd1 >= TIMEOUT_W) begin
                        mem_req_reg   <= 1'b0;
                        bus_error_reg <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 8'd1;
                    end
                end
                DONE: begin
                    // The pipeline advances this cycle, so a still-present request is stale.
                    bus_error_reg <= 1'b0;
                    state_reg     <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.mem_req   = mem_req_reg;
    assign bus.mem_we    = mem_we_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
    assign bus.mem_wstrb = mem_wstrb_reg;
    assign read_data     = read_data_reg;
    assign bus_error     = bus_error_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed-vector bench for mem_access_unit: each access is driven with the
// request held through DONE, and the observed bus activity is compared.
module tb_mem_access_unit;

    logic        CLK;
    logic        RESET;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] address;
    logic [31:0] store_data;
    logic [31:0] read_data;
    logic        stall;
    logic        misaligned;
    logic        bus_error;

    int n_vec;
    int n_miss;

    mem_access_unit_if bus ();

    mem_access_unit #(.TIMEOUT(255)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .address    (address),
        .store_data (store_data),
        .bus        (bus),
        .read_data  (read_data),
        .stall      (stall),
        .misaligned (misaligned),
        .bus_error  (bus_error)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    int          r_stall, r_req, r_err;
    logic        r_mis, r_we;
    logic [31:0] r_addr, r_wdata;
    logic [3:0]  r_wstrb;

    // rdy_at: WAIT cycle (1-based) in which mem_ready is raised; <=0 means never.
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] sd,
                             input int rdy_at, input logic [31:0] rdata);
        int   wcnt;
        logic prev_req, seen, done;
        r_stall = 0; r_req = 0; r_err = 0; r_mis = 1'b0; r_we = 1'b0;
        r_addr = 32'd0; r_wdata = 32'd0; r_wstrb = 4'd0;
        wcnt = 0; prev_req = 1'b0; seen = 1'b0; done = 1'b0;
        @(posedge CLK); #1;
        mem_read = rd; mem_write = wr; funct3 = f3; address = addr; store_data = sd;
        bus.mem_ready = 1'b0; bus.mem_rdata = rdata;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            @(negedge CLK);
            if (stall) r_stall++;
            if (misaligned) r_mis = 1'b1;
            if (bus_error) r_err++;
            if (bus.mem_req && !prev_req) begin
                r_req++;
                r_addr = bus.mem_addr; r_we = bus.mem_we;
                r_wdata = bus.mem_wdata; r_wstrb = bus.mem_wstrb;
            end
            if (bus.mem_req) begin
                seen = 1'b1;
                wcnt++;
                bus.mem_ready = (wcnt == rdy_at);
            end else begin
                bus.mem_ready = 1'b0;
                if (seen || cyc >= 3) done = 1'b1;
            end
            prev_req = bus.mem_req;
        end
        check("cycle_bound", 32'(done), 32'd1);
        @(posedge CLK); #1;
        mem_read = 1'b0; mem_write = 1'b0; bus.mem_ready = 1'b0;
        repeat (2) begin
            @(negedge CLK);
            if (stall) r_stall++;
            if (bus_error) r_err++;
            if (bus.mem_req && !prev_req) r_req++;
            prev_req = bus.mem_req;
        end
    endtask

    initial begin
        n_vec = 0; n_miss = 0;
        RESET = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'd0;
        address = 32'd0; store_data = 32'd0;
        bus.mem_ready = 1'b0; bus.mem_rdata = 32'd0;
        #1 RESET = 1'b0;
        @(negedge CLK);
        check("rst_mem_req",   32'(bus.mem_req), 32'd0);
        check("rst_mem_we",    32'(bus.mem_we), 32'd0);
        check("rst_mem_addr",  bus.mem_addr, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("rst_mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
        check("rst_read_data", read_data, 32'd0);
        check("rst_bus_error", 32'(bus_error), 32'd0);
        check("rst_stall",     32'(stall), 32'd0);
        @(posedge CLK); #1 RESET = 1'b1;

        // LB 0x1003, data after 2 wait cycles
        do_access(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'd0, 2, 32'h80FF_1234);
        check("lb_stall_cycles", 32'(r_stall), 32'd3);
        check("lb_req_count",    32'(r_req), 32'd1);
        check("lb_mem_addr",     r_addr, 32'h0000_1000);
        check("lb_mem_we",       32'(r_we), 32'd0);
        check("lb_read_data",    read_data, 32'hFFFF_FF80);
        check("lb_misaligned",   32'(r_mis), 32'd0);

        // SH 0x2002
        do_access(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 1, 32'h1357_9BDF);
        check("sh_mem_we",     32'(r_we), 32'd1);
        check("sh_mem_wstrb",  32'(r_wstrb), 32'h0000_000C);
        check("sh_mem_wdata",  r_wdata, 32'hABCD_ABCD);
        check("sh_mem_addr",   r_addr, 32'h0000_2000);
        check("sh_read_data",  read_data, 32'hFFFF_FF80);
        check("sh_req_count",  32'(r_req), 32'd1);
        check("sh_stall",      32'(r_stall), 32'd2);

        // LW misaligned
        do_access(1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'd0, 1, 32'd0);
        check("lw_mis_flag",  32'(r_mis), 32'd1);
        check("lw_mis_stall", 32'(r_stall), 32'd0);
        check("lw_mis_req",   32'(r_req), 32'd0);

        do_access(1'b1, 1'b0, 3'b100, 32'h0000_1001, 32'd0, 1, 32'h80FF_1234);
        check("lbu_read_data", read_data, 32'h0000_0012);
        do_access(1'b1, 1'b0, 3'b001, 32'h0000_1002, 32'd0, 3, 32'h80FF_1234);
        check("lh_read_data", read_data, 32'hFFFF_80FF);
        check("lh_stall", 32'(r_stall), 32'd4);
        do_access(1'b1, 1'b0, 3'b101, 32'h0000_1000, 32'd0, 1, 32'h80FF_9234);
        check("lhu_read_data", read_data, 32'h0000_9234);
        do_access(1'b1, 1'b0, 3'b010, 32'h0000_7000, 32'd0, 1, 32'hCAFE_F00D);
        check("lw_read_data", read_data, 32'hCAFE_F00D);

        do_access(1'b0, 1'b1, 3'b000, 32'h0000_5001, 32'h1234_56AB, 1, 32'd0);
        check("sb_mem_wstrb", 32'(r_wstrb), 32'h0000_0002);
        check("sb_mem_wdata", r_wdata, 32'hABAB_ABAB);
        do_access(1'b0, 1'b1, 3'b010, 32'h0000_6000, 32'hDEAD_BEEF, 1, 32'd0);
        check("sw_mem_wstrb", 32'(r_wstrb), 32'h0000_000F);
        check("sw_mem_wdata", r_wdata, 32'hDEAD_BEEF);
        check("sw_read_data", read_data, 32'hCAFE_F00D);

        // read and write together: store wins
        do_access(1'b1, 1'b1, 3'b000, 32'h0000_5003, 32'h0000_0077, 1, 32'h1111_1111);
        check("rw_mem_we",    32'(r_we), 32'd1);
        check("rw_mem_wstrb", 32'(r_wstrb), 32'h0000_0008);
        check("rw_read_data", read_data, 32'hCAFE_F00D);

        do_access(1'b0, 1'b1, 3'b100, 32'h0000_4000, 32'd0, 1, 32'd0);
        check("sbu_mis_flag", 32'(r_mis), 32'd1);
        check("sbu_mis_req",  32'(r_req), 32'd0);
        do_access(1'b1, 1'b0, 3'b011, 32'h0000_4000, 32'd0, 1, 32'd0);
        check("f3_011_mis_flag", 32'(r_mis), 32'd1);

        // LHU with no response: timeout after 255 WAIT cycles
        do_access(1'b1, 1'b0, 3'b101, 32'h0000_4002, 32'd0, 0, 32'h5555_5555);
        check("to_err_pulses", 32'(r_err), 32'd1);
        check("to_stall",      32'(r_stall), 32'd256);
        check("to_read_data",  read_data, 32'hCAFE_F00D);
        check("to_idle_stall", 32'(stall), 32'd0);

        // reset in WAIT with mem_ready in the same cycle
        @(posedge CLK); #1;
        mem_read = 1'b1; funct3 = 3'b010; address = 32'h0000_8000; bus.mem_rdata = 32'h1111_2222;
        @(negedge CLK);
        @(negedge CLK);
        check("rw_wait_req", 32'(bus.mem_req), 32'd1);
        bus.mem_ready = 1'b1;
        #2 RESET = 1'b0;
        #1;
        check("rst_wait_req",  32'(bus.mem_req), 32'd0);
        check("rst_wait_rdat", read_data, 32'd0);
        mem_read = 1'b0;
        #1 check("rst_wait_stall", 32'(stall), 32'd0);
        @(posedge CLK); #1;
        check("rst_hold_rdat", read_data, 32'd0);
        RESET = 1'b1; bus.mem_ready = 1'b0;
        mem_read = 1'b1; funct3 = 3'b010; address = 32'h0000_9004; bus.mem_rdata = 32'h5A5A_0001;
        @(posedge CLK); @(negedge CLK);
        check("post_rst_req",  32'(bus.mem_req), 32'd1);
        check("post_rst_addr", bus.mem_addr, 32'h0000_9004);
        bus.mem_ready = 1'b1;
        @(negedge CLK);
        check("post_rst_rdat", read_data, 32'h5A5A_0001);
        check("post_rst_done", 32'(bus.mem_req), 32'd0);
        @(posedge CLK); #1;
        mem_read = 1'b0; bus.mem_ready = 1'b0;
        @(negedge CLK);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
